// File: rtl/moh_apb_slave_mem_pkg.sv
// Shared definitions for the APB3 memory slave.
//   state_e     : transfer FSM states (IDLE, ACCESS)
//   WAIT_LSB/W  : position and width of the wait-state field in CTRL
//   WP_BIT      : memory write-protect bit in CTRL
//   ctrl_addr_f : CTRL register address (all-ones word address)
package moh_apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int WAIT_LSB = 0;
    localparam int WAIT_W   = 4;
    localparam int WP_BIT   = 4;

    // CTRL sits at the top of the address space: 2^aw - 1.
    function automatic logic [31:0] ctrl_addr_f(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

endpackage

// File: rtl/moh_apb_slave_mem_wait_cnt.sv
// Loadable wait-state down-counter.
//   clk, rst_n : clock and active-low async reset
//   load       : load load_val this cycle (wins over dec)
//   load_val   : wait-state count to load
//   dec        : decrement by one; saturates at zero, never wraps
//   zero       : counter currently holds zero
module moh_apb_wait_cnt
    import moh_apb_slave_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/moh_apb_slave_mem.sv
// APB3 slave with a word-addressed memory, a control register (wait states
// and write-protect) and error responses for unmapped or protected accesses.
//   clk     : sole clock, rising edge
//   reset   : asynchronous active-low reset (deasserted synchronously inside)
//   psel    : APB select
//   addr    : word address (0..DEPTH-1 memory, all-ones = CTRL)
//   wdata   : write data
//   enable  : APB enable (access phase)
//   write   : 1 = write, 0 = read
//   rdata   : read data, valid while ready=1 on a read; holds otherwise
//   ready   : transfer completes this cycle
//   slverr  : error response, only ever high together with ready
//
// Handshake: a transfer begins with a setup cycle (psel=1, enable=0) seen in
// IDLE. The master then holds psel=1, enable=1 while ready=0; the cycle with
// psel & enable & ready is the single completion cycle, where rdata/slverr
// are valid and writes commit. Dropping psel before that abandons the
// transfer without side effects.
module moh_apb_slave_mem
    import moh_apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  enable,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  slverr
);

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(ctrl_addr_f(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reset synchroniser: assertion is immediate, release waits two edges.
    logic [1:0] rst_sync_q;
    logic [1:0] rst_sync_d;
    logic       rst_n;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n = rst_sync_q[1];

    // State
    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic                  write_q,  write_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic                  err_q,    err_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [WAIT_W-1:0]     wait_q,   wait_d;
    logic                  wp_q,     wp_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_zero;
    logic                  commit_mem;

    // Decode of the setup-cycle address (live bus) and the latched address.
    logic                  setup_is_mem;
    logic                  setup_is_ctrl;
    logic                  setup_err;
    logic                  lat_is_mem;
    logic [DATA_WIDTH-1:0] ctrl_rd;

    always_comb begin
        setup_is_mem  = (addr < DEPTH_A);
        setup_is_ctrl = (addr == CTRL_ADDR);
        // Protection is judged against WP as it stands at setup.
        setup_err     = !(setup_is_mem || setup_is_ctrl) ||
                        (write && setup_is_mem && wp_q);
        lat_is_mem    = (addr_q < DEPTH_A);

        ctrl_rd                         = '0;
        ctrl_rd[WAIT_LSB +: WAIT_W]     = wait_q;
        ctrl_rd[WP_BIT]                 = wp_q;
    end

    moh_apb_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (wait_q),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // FSM next-state and datapath
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        wait_d     = wait_q;
        wp_d       = wp_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        commit_mem = 1'b0;

        case (state_q)
            IDLE: begin
                // psel with enable but no prior setup is not a transfer.
                if (psel && !enable) begin
                    state_d  = ACCESS;
                    addr_d   = addr;
                    write_d  = write;
                    wdata_d  = wdata;
                    err_d    = setup_err;
                    cnt_load = 1'b1;
                    if (!write) begin
                        if (setup_err) begin
                            rdata_d = '0;
                        end else if (setup_is_ctrl) begin
                            rdata_d = ctrl_rd;
                        end else begin
                            rdata_d = mem_q[addr[IDX_W-1:0]];
                        end
                    end
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (!psel) begin
                    state_d = IDLE;
                end else if (enable && cnt_zero) begin
                    state_d = IDLE;
                    // A write that did not error is either memory or CTRL.
                    if (write_q && !err_q) begin
                        if (lat_is_mem) begin
                            commit_mem = 1'b1;
                        end else begin
                            wait_d = wdata_q[WAIT_LSB +: WAIT_W];
                            wp_d   = wdata_q[WP_BIT];
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (commit_mem) begin
            mem_d[addr_q[IDX_W-1:0]] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wait_q  <= '0;
            wp_q    <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            wp_q    <= wp_d;
            mem_q   <= mem_d;
        end
    end

    assign ready  = (state_q == ACCESS) && cnt_zero;
    assign slverr = ready && err_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_moh_apb_slave_mem.sv
module tb_moh_apb_slave_mem;

    localparam int          AW     = 8;
    localparam int          DW     = 16;
    localparam int          DEPTH  = 128;
    localparam logic [7:0]  CTRL_A = 8'hFF;

    // Clock / reset
    logic          clk = 1'b0;
    logic          reset;
    logic          psel;
    logic          enable;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          slverr;

    always #5 clk = ~clk;

    moh_apb_slave_mem #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .psel   (psel),
        .addr   (addr),
        .wdata  (wdata),
        .enable (enable),
        .write  (write),
        .rdata  (rdata),
        .ready  (ready),
        .slverr (slverr)
    );

    // Scoreboard
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the slave's architectural state
    logic [DW-1:0] m_mem [DEPTH];
    logic [3:0]    m_wait;
    logic          m_wp;
    logic [DW-1:0] m_last;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_wait = '0;
        m_wp   = 1'b0;
        m_last = '0;
    endtask

    // Expected response of one complete transfer, then apply its effect.
    function automatic void model_xfer(input bit wr, input logic [7:0] a, input logic [DW-1:0] d,
                                       output logic [DW-1:0] rd, output bit err, output int acc);
        bit in_mem;
        bit in_ctrl;
        in_mem  = int'(a) < DEPTH;
        in_ctrl = (a == CTRL_A);
        err     = (!in_mem && !in_ctrl) || (wr && in_mem && m_wp);
        acc     = int'(m_wait) + 1;
        if (wr) begin
            rd = m_last;
            if (!err) begin
                if (in_mem) m_mem[a[6:0]] = d;
                else begin
                    m_wait = d[3:0];
                    m_wp   = d[4];
                end
            end
        end else begin
            if (err)          rd = '0;
            else if (in_ctrl) rd = {11'd0, m_wp, m_wait};
            else              rd = m_mem[a[6:0]];
            m_last = rd;
        end
    endfunction

    // Driver: called at a negedge with the bus idle; returns at a negedge
    // with the bus idle again. acc counts access-phase cycles up to ready.
    task automatic do_xfer(input bit wr, input logic [7:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rd, output logic err, output int acc,
                           output bit early_err);
        psel   = 1'b1;
        enable = 1'b0;
        write  = wr;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        enable    = 1'b1;
        early_err = 1'b0;
        acc       = 1;
        while (ready !== 1'b1 && acc < 40) begin
            if (slverr !== 1'b0) early_err = 1'b1;
            @(negedge clk);
            acc++;
        end
        rd  = rdata;
        err = slverr;
        @(negedge clk);
        psel   = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
    endtask

    task automatic check_xfer(input string tag, input bit wr, input logic [7:0] a,
                              input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                              input bit exp_err, input int exp_acc);
        logic [DW-1:0] rd;
        logic          err;
        int            acc;
        bit            early;
        do_xfer(wr, a, d, rd, err, acc, early);
        chk({tag, "_cycles"}, acc, exp_acc);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_slverr"}, err, exp_err);
        chk({tag, "_slverr_while_waiting"}, early, 0);
    endtask

    task automatic model_check(input string tag, input bit wr, input logic [7:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] e_rd;
        bit            e_err;
        int            e_acc;
        model_xfer(wr, a, d, e_rd, e_err, e_acc);
        check_xfer(tag, wr, a, d, e_rd, e_err, e_acc);
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [DW-1:0] exp_rd);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_slverr"}, slverr, 0);
        chk({tag, "_rdata"}, rdata, exp_rd);
    endtask

    typedef struct {
        bit            wr;
        logic [7:0]    a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        int            exp_acc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        logic [DW-1:0] s_rd;
        bit            s_err;
        int            s_acc;

        reset  = 1'b0;
        psel   = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        addr   = '0;
        wdata  = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_outputs("in_reset", 16'h0000);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("after_reset", 16'h0000);

        // Directed table: wr, addr, wdata, exp rdata, exp slverr, exp access cycles
        tbl[0]  = '{1'b1, 8'h03, 16'hA5A5, 16'h0000, 1'b0, 1};
        tbl[1]  = '{1'b0, 8'h03, 16'h0000, 16'hA5A5, 1'b0, 1};
        tbl[2]  = '{1'b1, 8'hFF, 16'h0003, 16'hA5A5, 1'b0, 1};
        tbl[3]  = '{1'b0, 8'h03, 16'h0000, 16'hA5A5, 1'b0, 4};
        tbl[4]  = '{1'b1, 8'hFF, 16'h0013, 16'hA5A5, 1'b0, 4};
        tbl[5]  = '{1'b1, 8'h03, 16'h1234, 16'hA5A5, 1'b1, 4};
        tbl[6]  = '{1'b0, 8'h03, 16'h0000, 16'hA5A5, 1'b0, 4};
        tbl[7]  = '{1'b1, 8'hFF, 16'h0000, 16'hA5A5, 1'b0, 4};
        tbl[8]  = '{1'b0, 8'h03, 16'h0000, 16'hA5A5, 1'b0, 1};
        tbl[9]  = '{1'b0, 8'h80, 16'h0000, 16'h0000, 1'b1, 1};
        tbl[10] = '{1'b1, 8'hFF, 16'hFFE2, 16'h0000, 1'b0, 1};
        tbl[11] = '{1'b0, 8'hFF, 16'h0000, 16'h0002, 1'b0, 3};
        tbl[12] = '{1'b1, 8'hFF, 16'h0000, 16'h0002, 1'b0, 3};
        tbl[13] = '{1'b1, 8'h03, 16'hBEEF, 16'h0002, 1'b0, 1};
        tbl[14] = '{1'b0, 8'h03, 16'h0000, 16'hBEEF, 1'b0, 1};

        for (int i = 0; i < 15; i++) begin
            model_xfer(tbl[i].wr, tbl[i].a, tbl[i].d, s_rd, s_err, s_acc);
            check_xfer($sformatf("vec%0d", i), tbl[i].wr, tbl[i].a, tbl[i].d,
                       tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_acc);
        end

        // Abort: drop psel in the middle of a WAIT=5 write to 0x10
        model_check("set_wait5", 1'b1, CTRL_A, 16'h0005);
        psel  = 1'b1;
        enable = 1'b0;
        write = 1'b1;
        addr  = 8'h10;
        wdata = 16'h7777;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk_idle_outputs($sformatf("abort_wait%0d", i), m_last);
            @(negedge clk);
        end
        psel   = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("abort_after%0d", i), m_last);
        end
        model_check("clr_wait", 1'b1, CTRL_A, 16'h0000);
        model_xfer(1'b0, 8'h10, 16'h0, s_rd, s_err, s_acc);
        check_xfer("abort_addr10", 1'b0, 8'h10, 16'h0, 16'h0000, 1'b0, 1);

        // enable=1 without a setup cycle is ignored
        psel   = 1'b1;
        enable = 1'b1;
        write  = 1'b1;
        addr   = 8'h03;
        wdata  = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("no_setup%0d", i), m_last);
        end
        psel   = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        @(negedge clk);
        model_check("no_setup_readback", 1'b0, 8'h03, 16'h0);

        // Reset in the middle of a WAIT=7 write
        model_check("rst_pre_wr", 1'b1, 8'h20, 16'h7E57);
        model_check("rst_pre_rd", 1'b0, 8'h20, 16'h0);
        model_check("set_wait7", 1'b1, CTRL_A, 16'h0007);
        psel   = 1'b1;
        enable = 1'b0;
        write  = 1'b1;
        addr   = 8'h20;
        wdata  = 16'h5555;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_access_rdata", rdata, 16'h7E57);
        reset = 1'b0;
        #1;
        chk_idle_outputs("rst_immediate", 16'h0000);
        psel   = 1'b0;
        enable = 1'b0;
        write  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        chk_idle_outputs("rst_release", 16'h0000);
        check_xfer("rst_ctrl", 1'b0, CTRL_A, 16'h0, 16'h0000, 1'b0, 1);
        check_xfer("rst_mem20", 1'b0, 8'h20, 16'h0, 16'h0000, 1'b0, 1);
        check_xfer("rst_mem03", 1'b0, 8'h03, 16'h0, 16'h0000, 1'b0, 1);

        // Randomised transfers against the model
        for (int i = 0; i < 80; i++) begin
            bit            wr;
            logic [7:0]    a;
            logic [DW-1:0] d;
            logic [DW-1:0] rd;
            logic          err;
            int            acc;
            bit            early;
            int            sel;
            sel = $urandom_range(0, 9);
            wr  = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            if (sel < 3)      a = 8'($urandom_range(0, 7));
            else if (sel < 6) a = 8'($urandom_range(0, DEPTH - 1));
            else if (sel < 8) a = CTRL_A;
            else              a = 8'($urandom_range(DEPTH, 254));
            model_xfer(wr, a, d, s_rd, s_err, s_acc);
            exp_q.push_back(s_rd);
            do_xfer(wr, a, d, rd, err, acc, early);
            chk($sformatf("rand%0d_rdata", i), rd, exp_q.pop_front());
            chk($sformatf("rand%0d_slverr", i), err, s_err);
            chk($sformatf("rand%0d_cycles", i), acc, s_acc);
            chk($sformatf("rand%0d_slverr_while_waiting", i), early, 0);
        end

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/moh_apb_slave_mem.md
# moh_apb_slave_mem

Parametrised APB3 slave holding a word-addressed memory, one control register, programmable wait states and error responses. It is the standard DUT behind the APB3 agent in the example testbench: it replaces a fixed zero-wait slave so the UVC's wait-state, `ready`-stall and `slverr` paths can be exercised. It is driven directly from the `moh_apb_if` signals and runs on the interface clock.

## Interface
- `ADDR_WIDTH`, 8, APB address width (word addresses).
- `DATA_WIDTH`, 16, data width; must be ≥ 5.
- `DEPTH`, 128, memory words at addresses 0..DEPTH-1; must be ≤ 2^ADDR_WIDTH − 1.
- `clk`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `psel`  in  1  APB select.
- `addr`  in  ADDR_WIDTH  transfer address.
- `wdata`  in  DATA_WIDTH  write data.
- `enable`  in  1  APB enable (access phase).
- `write`  in  1  1 = write, 0 = read.
- `rdata`  out  DATA_WIDTH  read data, valid while `ready`=1 on a read.
- `ready`  out  1  transfer completes this cycle.
- `slverr`  out  1  error response, qualified by `ready`.

## Operation
- Address map:
  - 0..DEPTH-1: memory.
  - CTRL_ADDR = 2^ADDR_WIDTH − 1: control register.
  - All other addresses are unmapped.
- CTRL fields: [3:0] WAIT (wait states per transfer), [4] WP (memory write-protect). Other bits read 0 and ignore writes.
- FSM states: IDLE, ACCESS.
- IDLE → ACCESS on `psel`=1, `enable`=0 (setup cycle). At that edge the block:
  - latches `addr`, `write`, `wdata`;
  - loads the wait counter with CTRL.WAIT;
  - computes the error flag;
  - for reads, loads `rdata` from the memory or CTRL (0 on error).
- In IDLE, `psel`=1 with `enable`=1 has no preceding setup and is ignored. State stays IDLE and `ready` stays 0.
- ACCESS:
  - `ready` = (counter == 0). The counter decrements each ACCESS cycle while non-zero.
  - The completion edge is `psel` & `enable` & `ready`. On it, a write without error commits to memory or CTRL, and the FSM returns to IDLE.
  - Back-to-back transfers need a new setup cycle.
- `psel`=0 in ACCESS aborts: return to IDLE, no write, no response.
- Error conditions (`slverr`=1 on the completion cycle, no state change):
  - unmapped address;
  - memory write while CTRL.WP=1.
- CTRL writes are never protected.
- `slverr` is 0 whenever `ready`=0.
- `rdata` holds its last value between reads and after writes.

## Timing
- Reset (async assert, sync deassert inside the block): FSM IDLE, `ready`=0, `slverr`=0, `rdata`=0, CTRL=0, memory cleared to 0.
- Reset asserted mid-transfer: immediate return to reset values, no partial write.
- WAIT=N gives N+1 ACCESS cycles. `ready` is low for the first N cycles and high on cycle N+1.
- Minimum transfer length is 2 cycles (setup + access). This holds at WAIT=0.
- CTRL.WAIT written during a transfer takes effect from the next setup cycle.
- A read following a write to the same address returns the new data.
- Wait counter width is 4 bits, so no wrap: it saturates at 0.

## Structure
- Package `moh_apb_slave_pkg` holds:
  - the state enum (IDLE, ACCESS);
  - CTRL field constants: WAIT_LSB=0, WAIT_W=4, WP_BIT=4;
  - a function computing CTRL_ADDR from ADDR_WIDTH.
- Sub-module `moh_apb_wait_cnt`: 4-bit loadable down-counter with a `zero` flag, instantiated once.
- Memory, CTRL and decode live in the top module.

## Test plan
- Reset, then WAIT=0: write 0xA5A5 to addr 0x03 and read back. Each transfer takes 2 cycles and read returns 0xA5A5 with `slverr`=0.
- Write CTRL=0x0003, then read addr 0x03. `ready` is low for 3 access cycles and high on the 4th, with `rdata`=0xA5A5.
- Write CTRL WP=1, write 0x1234 to addr 0x03. `slverr`=1 on completion, and a later read returns 0xA5A5. A CTRL write clearing WP succeeds.
- Read addr 0x80 (unmapped with DEPTH=128). `slverr`=1, `rdata`=0. Read CTRL_ADDR 0xFF returns the programmed value.
- Drop `psel` during a WAIT=5 write to addr 0x10. No `ready` or `slverr`, and addr 0x10 still reads 0. Also apply `enable`=1 without setup: no response.
- Assert `reset` mid-access with WAIT=7. All outputs go to 0 immediately, and after release CTRL reads 0 and memory reads 0.
